// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns a single-ended PWM into a complementary high/low gate
// pair for a half-bridge. Every transition passes through a programmable
// both-low dead interval, so out_h and out_l can never be high together.
// Pulses shorter than the dead time are swallowed and flagged on pulse_drop.
//
// Handshake note: this block has no valid/ready interfaces. pwm_in is a plain
// asynchronous level, and every output is a registered level or strobe that
// is valid for the whole cycle after the clock edge that produced it.
module pwm_deadtime #(
  parameter int DT_WIDTH    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                pwm_in,
  input  logic [DT_WIDTH-1:0] dead_cycles,
  output logic                out_h,
  output logic                out_l,
  output logic                in_dead,
  output logic                pulse_drop,
  output logic [2:0]          state_dbg
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOW_ON    = 3'd1;
  localparam logic [2:0] DEAD_RISE = 3'd2;
  localparam logic [2:0] HIGH_ON   = 3'd3;
  localparam logic [2:0] DEAD_FALL = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic [2:0]             state, state_nxt;
  logic [DT_WIDTH-1:0]    cnt, cnt_nxt;
  logic                   from_idle, from_idle_nxt;
  logic                   drop_nxt;
  logic                   cnt_done;

  // pwm_in comes from a divided clock domain: shift it through SYNC_STAGES flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign pwm_s     = sync_q[SYNC_STAGES-1];
  assign cnt_done  = (cnt <= DT_WIDTH'(1));
  assign state_dbg = state;

  // Next-state logic. en has priority over pwm_s. from_idle remembers that the
  // current dead interval began at start-up, where there is no previous ON
  // side to fall back to, so a disagreeing pwm_s retargets instead of aborting.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    from_idle_nxt = from_idle;
    drop_nxt      = 1'b0;
    if (!en) begin
      state_nxt     = IDLE;
      cnt_nxt       = '0;
      from_idle_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt     = pwm_s ? DEAD_RISE : DEAD_FALL;
          cnt_nxt       = dead_cycles;
          from_idle_nxt = 1'b1;
        end
        LOW_ON: begin
          if (pwm_s) begin
            state_nxt     = DEAD_RISE;
            cnt_nxt       = dead_cycles;
            from_idle_nxt = 1'b0;
          end
        end
        HIGH_ON: begin
          if (!pwm_s) begin
            state_nxt     = DEAD_FALL;
            cnt_nxt       = dead_cycles;
            from_idle_nxt = 1'b0;
          end
        end
        DEAD_RISE: begin
          if (cnt_done && pwm_s) begin
            state_nxt     = HIGH_ON;
            from_idle_nxt = 1'b0;
          end else if (!pwm_s) begin
            if (from_idle) begin
              state_nxt = DEAD_FALL;
              cnt_nxt   = dead_cycles;
            end else begin
              state_nxt = LOW_ON;
              drop_nxt  = 1'b1;
            end
          end else begin
            // Only reached with cnt > 1, so the counter cannot wrap.
            cnt_nxt = cnt - DT_WIDTH'(1);
          end
        end
        DEAD_FALL: begin
          if (cnt_done && !pwm_s) begin
            state_nxt     = LOW_ON;
            from_idle_nxt = 1'b0;
          end else if (pwm_s) begin
            if (from_idle) begin
              state_nxt = DEAD_RISE;
              cnt_nxt   = dead_cycles;
            end else begin
              state_nxt = HIGH_ON;
              drop_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt - DT_WIDTH'(1);
          end
        end
        default: begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          from_idle_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, counter and outputs; outputs are decoded from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      from_idle  <= 1'b0;
      out_h      <= 1'b0;
      out_l      <= 1'b0;
      in_dead    <= 1'b0;
      pulse_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      from_idle  <= from_idle_nxt;
      out_h      <= (state_nxt == HIGH_ON);
      out_l      <= (state_nxt == LOW_ON);
      in_dead    <= (state_nxt == DEAD_RISE) || (state_nxt == DEAD_FALL);
      pulse_drop <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime (DT_WIDTH=8, SYNC_STAGES=2). Expected output
// vectors {out_h,out_l,in_dead,pulse_drop} are queued as each stimulus step is
// set up, then popped one per clock and compared 1 ns after the rising edge.
module tb_pwm_deadtime;

  localparam int W = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       pwm_in;
  logic [7:0] dead_cycles;
  logic       out_h;
  logic       out_l;
  logic       in_dead;
  logic       pulse_drop;
  logic [2:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  pwm_deadtime #(.DT_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pwm_in      (pwm_in),
    .dead_cycles (dead_cycles),
    .out_h       (out_h),
    .out_l       (out_l),
    .in_dead     (in_dead),
    .pulse_drop  (pulse_drop),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] obs();
    return {out_h, out_l, in_dead, pulse_drop};
  endfunction

  // driver tasks
  task automatic push_n(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic compare_one(input string tag);
    logic [W-1:0] e;
    logic [W-1:0] o;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%b expected=<empty queue>", tag, obs());
    end else begin
      e = exp_q.pop_front();
      o = obs();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
    end
  endtask

  task automatic check_n(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      compare_one(tag);
    end
  endtask

  // Overlap invariant sampled on every falling edge.
  always @(negedge clk) begin
    checks++;
    assert (!(out_h && out_l)) else begin
      errors++;
      $error("FAIL overlap observed out_h=%b out_l=%b expected not both 1", out_h, out_l);
    end
  end

  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    pwm_in      = 1'b0;
    dead_cycles = 8'd4;

    // reset state
    push_n(4'b0000, 3);
    check_n("reset", 3);

    // release with en=0 and pwm_in toggling: everything stays low
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pwm_in = ~pwm_in;
      push_n(4'b0000, 1);
      check_n("en0_toggle", 1);
    end
    push_n(4'b0000, 3);
    check_n("en0_settle", 3);

    // start-up into LOW_ON through a 4-cycle dead time
    en = 1'b1;
    push_n(4'b0010, 4);
    push_n(4'b0100, 4);
    check_n("startup_low", 8);

    // rising edge: out_l drops after k+2, out_h rises after k+6
    pwm_in = 1'b1;
    push_n(4'b0100, 2);
    push_n(4'b0010, 4);
    push_n(4'b1000, 3);
    check_n("rise_dt4", 9);

    // falling edge, symmetric
    pwm_in = 1'b0;
    push_n(4'b1000, 2);
    push_n(4'b0010, 4);
    push_n(4'b0100, 3);
    check_n("fall_dt4", 9);

    // 3-cycle pulse with dead_cycles=10 is swallowed
    dead_cycles = 8'd10;
    push_n(4'b0100, 2);
    push_n(4'b0010, 3);
    push_n(4'b0101, 1);
    push_n(4'b0100, 3);
    pwm_in = 1'b1;
    check_n("short_pulse", 3);
    pwm_in = 1'b0;
    check_n("short_pulse", 6);

    // dead_cycles=0 gives exactly one both-low cycle each way
    dead_cycles = 8'd0;
    pwm_in = 1'b1;
    push_n(4'b0100, 2);
    push_n(4'b0010, 1);
    push_n(4'b1000, 3);
    check_n("rise_dt0", 6);
    pwm_in = 1'b0;
    push_n(4'b1000, 2);
    push_n(4'b0010, 1);
    push_n(4'b0100, 3);
    check_n("fall_dt0", 6);

    // dead_cycles changed 4->8 mid-dead: current interval stays 4, next is 8
    dead_cycles = 8'd4;
    pwm_in = 1'b1;
    push_n(4'b0100, 2);
    push_n(4'b0010, 4);
    push_n(4'b1000, 2);
    check_n("dt_hold", 3);
    dead_cycles = 8'd8;
    check_n("dt_hold", 5);
    pwm_in = 1'b0;
    push_n(4'b1000, 2);
    push_n(4'b0010, 8);
    push_n(4'b0100, 3);
    check_n("dt_next8", 13);

    // reach HIGH_ON, then drop en
    dead_cycles = 8'd4;
    pwm_in = 1'b1;
    push_n(4'b0100, 2);
    push_n(4'b0010, 4);
    push_n(4'b1000, 2);
    check_n("rise_again", 8);
    en = 1'b0;
    push_n(4'b0000, 3);
    check_n("en_drop", 3);

    // re-enable into DEAD_RISE, then pulse rst asynchronously mid-dead
    en = 1'b1;
    push_n(4'b0010, 2);
    check_n("reenable_dead", 2);
    #2;
    rst = 1'b1;
    #1;
    push_n(4'b0000, 1);
    compare_one("async_rst");
    push_n(4'b0000, 2);
    check_n("rst_hold", 2);

    // release with pwm_in high: synchroniser restarts at 0 so the FSM starts
    // in DEAD_FALL, then retargets to DEAD_RISE with a fresh count
    rst = 1'b0;
    push_n(4'b0010, 6);
    push_n(4'b1000, 2);
    check_n("retarget", 8);

    // random soak, overlap monitor only
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) pwm_in = ~pwm_in;
      en          = ($urandom_range(0, 63) != 0);
      dead_cycles = 8'($urandom_range(0, 12));
      @(posedge clk);
      #1;
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
